// File: rtl/ps2_kbd_rx_if.sv
// PS/2 keyboard receiver bus: raw keyboard lines in, decoded scan code and
// status strobes out. The keyboard/consumer side uses master, the receiver
// uses slave.
interface ps2_kbd_rx_if;
  logic       PS2_CLK;
  logic       PS2_DAT;
  logic [7:0] KCODE;
  logic       KCOME;
  logic       PERR;
  logic       FERR;

  modport master (
    output PS2_CLK, PS2_DAT,
    input  KCODE, KCOME, PERR, FERR
  );

  modport slave (
    input  PS2_CLK, PS2_DAT,
    output KCODE, KCOME, PERR, FERR
  );
endinterface

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard frame receiver.
// Synchronizes the raw PS/2 clock/data lines into KCLK and detects falling
// edges of the PS/2 clock. It then assembles start/8 data/parity/stop frames
// and publishes valid scan codes with a one-cycle KCOME strobe. Bad-stop
// frames raise FERR. A stalled partial frame is abandoned after
// TIMEOUT_CYCLES silent cycles.
// Optional build macro: PS2_PARITY_CHECK_EN. When it is defined, odd-parity
// failures drop the frame and pulse PERR. When it is undefined, the parity
// bit is captured but ignored and PERR stays 0.
module ps2_kbd_rx #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic          KCLK,
  input  logic          RSTN,
  ps2_kbd_rx_if.slave   bus
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

`ifdef PS2_PARITY_CHECK_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_e;

  // Synchronizer and edge detector state. Everything resets high to match
  // an idle bus, so no spurious edge appears after reset.
  logic [1:0] clk_s_q, dat_s_q;
  logic       clk_prev_q;
  logic       ps2_clk, ps2_dat, fall;

  // Frame FSM and datapath
  state_e          state_q, state_d;
  logic [7:0]      sr_q, sr_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic            par_q, par_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            tmo_hit;

  // Frame result decode and registered outputs
  logic            par_ok, stop_ok, stop_edge;
  logic            accept_d, perr_d, ferr_d;
  logic [7:0]      kcode_q, kcode_d;
  logic            kcome_q, perr_q, ferr_q;

  // Two-flop synchronizers on both PS/2 lines, plus the previous clock level
  always_ff @(posedge KCLK or negedge RSTN) begin
    if (!RSTN) begin
      clk_s_q    <= 2'b11;
      dat_s_q    <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      clk_s_q    <= {clk_s_q[0], bus.PS2_CLK};
      dat_s_q    <= {dat_s_q[0], bus.PS2_DAT};
      clk_prev_q <= clk_s_q[1];
    end
  end

  assign ps2_clk = clk_s_q[1];
  assign ps2_dat = dat_s_q[1];
  assign fall    = clk_prev_q & ~ps2_clk;

  // A falling edge in the same cycle overrides an expiring timeout
  assign tmo_hit = (state_q != S_IDLE) && !fall && (tmo_q == TMO_LAST);

  // FSM state register
  always_ff @(posedge KCLK or negedge RSTN) begin
    if (!RSTN) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic: advance one step per PS/2 falling edge
  always_comb begin
    state_d = state_q;
    if (tmo_hit) begin
      state_d = S_IDLE;
    end else if (fall) begin
      case (state_q)
        S_IDLE:   if (!ps2_dat) state_d = S_DATA;
        S_DATA:   if (bitcnt_q == 3'd7) state_d = S_PARITY;
        S_PARITY: state_d = S_STOP;
        S_STOP:   state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // FSM output logic: datapath next-state and frame verdict at the stop edge
  always_comb begin
    sr_d     = sr_q;
    bitcnt_d = bitcnt_q;
    par_d    = par_q;
    tmo_d    = (state_q == S_IDLE || fall) ? '0 : tmo_q + 1'b1;

    if (tmo_hit) begin
      bitcnt_d = 3'd0;
    end else if (fall) begin
      case (state_q)
        S_IDLE:   bitcnt_d = 3'd0;
        S_DATA: begin
          sr_d     = {ps2_dat, sr_q[7:1]};   // LSB arrives first
          bitcnt_d = bitcnt_q + 3'd1;
        end
        S_PARITY: par_d = ps2_dat;
        default:  ;
      endcase
    end

    stop_edge = fall && (state_q == S_STOP);
    stop_ok   = ps2_dat;
    par_ok    = ^{sr_q, par_q};             // odd parity over data + parity
    ferr_d    = stop_edge && !stop_ok;
    perr_d    = stop_edge && stop_ok && !par_ok && PARITY_EN;
    accept_d  = stop_edge && stop_ok && (par_ok || !PARITY_EN);
    kcode_d   = accept_d ? sr_q : kcode_q;
  end

  // Datapath registers
  always_ff @(posedge KCLK or negedge RSTN) begin
    if (!RSTN) begin
      sr_q     <= 8'h00;
      bitcnt_q <= 3'd0;
      par_q    <= 1'b0;
      tmo_q    <= '0;
    end else begin
      sr_q     <= sr_d;
      bitcnt_q <= bitcnt_d;
      par_q    <= par_d;
      tmo_q    <= tmo_d;
    end
  end

  // Output registers: code and strobes appear the cycle after the stop edge
  always_ff @(posedge KCLK or negedge RSTN) begin
    if (!RSTN) begin
      kcode_q <= 8'h00;
      kcome_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      kcode_q <= kcode_d;
      kcome_q <= accept_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign bus.KCODE = kcode_q;
  assign bus.KCOME = kcome_q;
  assign bus.PERR  = PARITY_EN ? perr_q : 1'b0;
  assign bus.FERR  = ferr_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Self-checking bench for ps2_kbd_rx: table of frames plus hand-written
// timing, back-to-back, stall/timeout and mid-frame reset sequences.
// Expected strobes are queued when a frame is sent and matched by a monitor.
module tb_ps2_kbd_rx;

  localparam int TMO = 64;

`ifdef PS2_PARITY_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  typedef struct {
    int         kind;   // 0 = KCOME with code, 1 = PERR, 2 = FERR
    logic [7:0] code;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    exp_t       exp;
  } vec_t;

  logic KCLK = 1'b0;
  logic RSTN = 1'b0;
  ps2_kbd_rx_if bus();

  ps2_kbd_rx #(.TIMEOUT_CYCLES(TMO)) dut (
    .KCLK (KCLK),
    .RSTN (RSTN),
    .bus  (bus.slave)
  );

  always #5 KCLK = ~KCLK;

  int         checks = 0;
  int         errors = 0;
  exp_t       sb[$];
  logic [7:0] last_code = 8'h00;

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge KCLK);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // One PS/2 bit: data set while clock high, then a falling edge
  task automatic send_bit(input logic b, input int h);
    bus.PS2_DAT = b;
    cyc(h);
    bus.PS2_CLK = 1'b0;
    cyc(h);
    bus.PS2_CLK = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int h);
    logic [7:0] dd;
    dd = d;
    send_bit(1'b0, h);
    for (int i = 0; i < 8; i++) send_bit(dd[i], h);
    send_bit(p, h);
    send_bit(s, h);
  endtask

  task automatic push(input int kind, input logic [7:0] code);
    exp_t e;
    e.kind = kind;
    e.code = code;
    sb.push_back(e);
  endtask

  vec_t vecs[8];

  initial begin
    logic [7:0] c1c;
    exp_t       bad_par;

    bus.PS2_CLK = 1'b1;
    bus.PS2_DAT = 1'b1;

    // Scoreboard monitor: sample strobes on the falling edge of KCLK
    fork
      forever begin
        @(negedge KCLK);
        if (RSTN && (bus.KCOME || bus.PERR || bus.FERR)) begin
          int   gk;
          exp_t e;
          gk = bus.KCOME ? 0 : (bus.PERR ? 1 : 2);
          checks++;
          if (int'(bus.KCOME) + int'(bus.PERR) + int'(bus.FERR) > 1) begin
            errors++;
            $display("FAIL strobe_exclusive kcome=%0b perr=%0b ferr=%0b",
                     bus.KCOME, bus.PERR, bus.FERR);
          end else if (sb.size() == 0) begin
            errors++;
            $display("FAIL strobe_unexpected kind=%0d code=%0h", gk, bus.KCODE);
          end else begin
            e = sb.pop_front();
            if (gk != e.kind || bus.KCODE !== ((e.kind == 0) ? e.code : last_code)) begin
              errors++;
              $display("FAIL strobe_match got kind=%0d code=%0h want kind=%0d code=%0h",
                       gk, bus.KCODE, e.kind, (e.kind == 0) ? e.code : last_code);
            end
            if (e.kind == 0) last_code = e.code;
          end
        end
      end
    join_none

    bad_par.kind = PCHK ? 1 : 0;
    bad_par.code = 8'h1C;
    vecs[0] = '{8'h1C, 1'b0, 1'b1, '{0, 8'h1C}};
    vecs[1] = '{8'hF0, 1'b1, 1'b1, '{0, 8'hF0}};
    vecs[2] = '{8'h1C, 1'b1, 1'b1, bad_par};
    vecs[3] = '{8'h12, 1'b1, 1'b0, '{2, 8'h00}};
    vecs[4] = '{8'h00, 1'b1, 1'b1, '{0, 8'h00}};
    vecs[5] = '{8'hFF, 1'b1, 1'b1, '{0, 8'hFF}};
    vecs[6] = '{8'hA5, 1'b1, 1'b1, '{0, 8'hA5}};
    vecs[7] = '{8'h12, 1'b0, 1'b0, '{2, 8'h00}};

    // Reset state
    cyc(4);
    chk("rst_kcode", {24'h0, bus.KCODE}, 32'h0);
    chk("rst_kcome", {31'h0, bus.KCOME}, 32'h0);
    chk("rst_perr",  {31'h0, bus.PERR},  32'h0);
    chk("rst_ferr",  {31'h0, bus.FERR},  32'h0);
    RSTN = 1'b1;
    cyc(3);

    // 0x1C with exact KCOME latency: high only in the 3rd cycle after
    // the stop clock drop (2 sync stages, then one registered output)
    c1c = 8'h1C;
    push(0, 8'h1C);
    send_bit(1'b0, 4);
    for (int i = 0; i < 8; i++) send_bit(c1c[i], 4);
    send_bit(1'b0, 4);
    bus.PS2_DAT = 1'b1;
    cyc(4);
    bus.PS2_CLK = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      cyc(1);
      chk($sformatf("kcome_lat_c%0d", k), {31'h0, bus.KCOME}, {31'h0, (k == 3)});
    end
    bus.PS2_CLK = 1'b1;
    cyc(6);

    // Table of frames
    for (int v = 0; v < 8; v++) begin
      sb.push_back(vecs[v].exp);
      send_frame(vecs[v].data, vecs[v].par, vecs[v].stop, 4);
      cyc(6);
    end

    // Back-to-back at the fastest edge rate: next start edge 2 cycles later
    push(0, 8'hF0);
    push(0, 8'h1C);
    send_frame(8'hF0, 1'b1, 1'b1, 1);
    send_frame(8'h1C, 1'b0, 1'b1, 1);
    cyc(8);

    // Stall shorter than the timeout: frame still completes
    push(0, 8'h1C);
    send_bit(1'b0, 4);
    for (int i = 0; i < 4; i++) send_bit(c1c[i], 4);
    cyc(TMO - 24);
    for (int i = 4; i < 8; i++) send_bit(c1c[i], 4);
    send_bit(1'b0, 4);
    send_bit(1'b1, 4);
    cyc(6);

    // Stall past the timeout: partial frame dropped silently, next frame ok
    push(0, 8'h12);
    send_bit(1'b0, 4);
    for (int i = 0; i < 4; i++) send_bit(c1c[i], 4);
    cyc(TMO + 10);
    send_frame(8'h12, 1'b1, 1'b1, 4);
    cyc(6);

    // Reset in the middle of a frame
    send_bit(1'b0, 4);
    for (int i = 0; i < 5; i++) send_bit(c1c[i], 4);
    RSTN = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      chk($sformatf("midrst_outs_c%0d", k),
          {21'h0, bus.KCODE, bus.KCOME, bus.PERR, bus.FERR}, 32'h0);
    end
    last_code = 8'h00;
    RSTN = 1'b1;
    cyc(3);
    push(0, 8'h12);
    send_frame(8'h12, 1'b1, 1'b1, 4);
    cyc(20);

    chk("sb_drained", sb.size(), 32'h0);
    chk("final_kcode", {24'h0, bus.KCODE}, 32'h12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
